iterative_multiplier: RTL and testbench



---
 rtl/iterative_multiplier_if.sv | 27 ++
 rtl/iterative_multiplier.sv | 127 ++++++++++++
 tb/tb_iterative_multiplier.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_multiplier_if.sv
// Issue/result handshake bundle for iterative_multiplier.
//   master: issuer/consumer side (drives start_valid, mode, operands, flush, done_ready)
//   slave : multiplier side (drives start_ready, done_valid, result, full_product)
interface iterative_multiplier_if #(
    parameter int XLEN = 32
);
    logic              start_valid;
    logic              start_ready;
    logic [1:0]        mode;
    logic [XLEN-1:0]   operator_1;
    logic [XLEN-1:0]   operator_2;
    logic              flush;
    logic              done_valid;
    logic              done_ready;
    logic [XLEN-1:0]   result;
    logic [2*XLEN-1:0] full_product;

    modport master (
        output start_valid, mode, operator_1, operator_2, flush, done_ready,
        input  start_ready, done_valid, result, full_product
    );

    modport slave (
        input  start_valid, mode, operator_1, operator_2, flush, done_ready,
        output start_ready, done_valid, result, full_product
    );
endinterface

// File: rtl/iterative_multiplier.sv
// Multi-cycle RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU).
// Operand magnitudes are latched on issue; operand_2 is consumed one
// CHUNK-bit slice per cycle into a 2*XLEN accumulator, then one cycle
// applies the sign.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of iterative_multiplier_if (issue handshake, mode,
//           operands, flush, result handshake, result, full_product)
module iterative_multiplier #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iterative_multiplier_if.slave bus
);
    localparam int N  = XLEN / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * XLEN;
    localparam int SW = $clog2(PW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,
        MODE_MULH   = 2'b01,
        MODE_MULHSU = 2'b10,
        MODE_MULHU  = 2'b11
    } mode_t;

    state_t            state;
    mode_t             mode_q;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              neg;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     count;
    logic              done_valid_q;
    logic [XLEN-1:0]   result_q;
    logic [PW-1:0]     full_product_q;

    logic              sign1;
    logic              sign2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic [SW-1:0]     shamt;
    logic [CHUNK-1:0]  slice;
    logic [XLEN+CHUNK-1:0] pp;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     fixed;

    always_comb begin
        // op1 is signed for MULH/MULHSU, op2 only for MULH; MUL runs u x u
        // because the low half is sign-agnostic.
        sign1 = ((bus.mode == MODE_MULH) || (bus.mode == MODE_MULHSU)) &&
                bus.operator_1[XLEN-1];
        sign2 = (bus.mode == MODE_MULH) && bus.operator_2[XLEN-1];
        // Most negative value negates to itself, which is its correct
        // unsigned magnitude.
        abs1  = sign1 ? -bus.operator_1 : bus.operator_1;
        abs2  = sign2 ? -bus.operator_2 : bus.operator_2;

        shamt    = SW'(count) * SW'(CHUNK);
        slice    = CHUNK'(mag2 >> shamt);
        pp       = {{CHUNK{1'b0}}, mag1} * {{XLEN{1'b0}}, slice};
        acc_next = acc + (PW'(pp) << shamt);
        fixed    = neg ? -acc : acc;
    end

    assign bus.start_ready  = rst_n && (state == IDLE);
    assign bus.done_valid   = done_valid_q;
    assign bus.result       = result_q;
    assign bus.full_product = full_product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mode_q         <= MODE_MUL;
            mag1           <= '0;
            mag2           <= '0;
            neg            <= 1'b0;
            acc            <= '0;
            count          <= '0;
            done_valid_q   <= 1'b0;
            result_q       <= '0;
            full_product_q <= '0;
        end else if (bus.flush) begin
            // Kill wins over every transition; outputs keep last values.
            state        <= IDLE;
            done_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        mode_q <= mode_t'(bus.mode);
                        mag1   <= abs1;
                        mag2   <= abs2;
                        neg    <= sign1 ^ sign2;
                        acc    <= '0;
                        count  <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    full_product_q <= fixed;
                    result_q       <= (mode_q == MODE_MUL) ? fixed[XLEN-1:0]
                                                           : fixed[PW-1:XLEN];
                    done_valid_q   <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    if (bus.done_ready) begin
                        done_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_multiplier.sv
// Testbench for iterative_multiplier: one instance with CHUNK=16 (N=2) and
// one with CHUNK=8 (N=4), selected by 'sel'. Expected results are pushed to
// a scoreboard queue at issue and popped when done_valid rises.
module tb_iterative_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        sv = 1'b0;
    logic        fl = 1'b0;
    logic        dr = 1'b1;
    logic [1:0]  md = 2'b00;
    logic [31:0] o1 = '0;
    logic [31:0] o2 = '0;

    iterative_multiplier_if #(.XLEN(32)) bus_a ();
    iterative_multiplier_if #(.XLEN(32)) bus_b ();

    assign bus_a.start_valid = sv & ~sel;
    assign bus_b.start_valid = sv & sel;
    assign bus_a.mode = md;
    assign bus_b.mode = md;
    assign bus_a.operator_1 = o1;
    assign bus_b.operator_1 = o1;
    assign bus_a.operator_2 = o2;
    assign bus_b.operator_2 = o2;
    assign bus_a.flush = fl;
    assign bus_b.flush = fl;
    assign bus_a.done_ready = dr;
    assign bus_b.done_ready = dr;

    iterative_multiplier #(.XLEN(32), .CHUNK(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    iterative_multiplier #(.XLEN(32), .CHUNK(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    logic        sr_m, dv_m;
    logic [31:0] res_m;
    logic [63:0] fp_m;
    always_comb begin
        sr_m  = sel ? bus_b.start_ready  : bus_a.start_ready;
        dv_m  = sel ? bus_b.done_valid   : bus_a.done_valid;
        res_m = sel ? bus_b.result       : bus_a.result;
        fp_m  = sel ? bus_b.full_product : bus_a.full_product;
    end

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] fp;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [63:0] fp;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] last_fp = '0;
    logic [31:0] last_res = '0;

    function automatic logic [63:0] model_fp(input logic [1:0] m, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] model_res(input logic [1:0] m, input logic [63:0] fp);
        return (m == 2'b00) ? fp[31:0] : fp[63:32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!sr_m && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("issue_ready", 64'(sr_m), 64'd1);
        md = m; o1 = a; o2 = b; sv = 1'b1;
        @(posedge clk);
        #1;
        sv = 1'b0;
        o1 = $urandom;
        o2 = $urandom;
    endtask

    // Returns at the negedge where done_valid is first seen (or budget expires).
    task automatic wait_done(input int edges, input string nm);
        int k;
        logic seen;
        exp_t e;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            seen = dv_m;
        end
        chk({nm, "_lat"}, 64'(k), 64'(edges));
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: got result with empty scoreboard expected none", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_fp"}, fp_m, e.fp);
            chk({nm, "_res"}, 64'(res_m), 64'(e.res));
            last_fp = e.fp;
            last_res = e.res;
        end
    endtask

    task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] fp, input logic [31:0] res,
                          input int edges, input string nm);
        exp_t e;
        e.fp = fp;
        e.res = res;
        sb.push_back(e);
        issue(m, a, b);
        wait_done(edges, nm);
        @(negedge clk);
        chk({nm, "_sr_back"}, 64'(sr_m), 64'd1);
        chk({nm, "_dv_drop"}, 64'(dv_m), 64'd0);
    endtask

    task automatic run_rand(input logic [1:0] m, input int edges, input string nm);
        logic [31:0] a, b;
        logic [63:0] fp;
        logic [31:0] pick [6];
        pick[0] = 32'h0;
        pick[1] = 32'h1;
        pick[2] = 32'hFFFFFFFF;
        pick[3] = 32'h80000000;
        pick[4] = 32'h7FFFFFFF;
        pick[5] = $urandom;
        a = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
        b = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
        fp = model_fp(m, a, b);
        run_op(m, a, b, fp, model_res(m, fp), edges, nm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        exp_t e;
        tbl[0] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE};
        tbl[1] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 32'h00000000};
        tbl[2] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 64'h7FFFFFFF80000000, 32'h80000000};
        tbl[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 32'hFFFFFFFF};
        tbl[4] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA, 32'hFFFFFFFF};
        tbl[5] = '{2'b01, 32'h00000000, 32'h80000000, 64'h0000000000000000, 32'h00000000};
        tbl[6] = '{2'b11, 32'h00010000, 32'h00010000, 64'h0000000100000000, 32'h00000001};
        tbl[7] = '{2'b01, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000};
        tbl[8] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h8000000080000000, 32'h80000000};
        tbl[9] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'h00000001};

        // Reset state
        #12;
        chk("rst_dv_a", 64'(bus_a.done_valid), 64'd0);
        chk("rst_res_a", 64'(bus_a.result), 64'd0);
        chk("rst_fp_a", bus_a.full_product, 64'd0);
        chk("rst_dv_b", 64'(bus_b.done_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sr_a", 64'(bus_a.start_ready), 64'd1);
        chk("rst_sr_b", 64'(bus_b.start_ready), 64'd1);

        // Directed vectors, CHUNK=16 (N=2 -> 3 edges)
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].fp, tbl[i].res, 3, $sformatf("tbl%0d", i));
        end

        // Backpressure with ignored issue attempts
        dr = 1'b0;
        e.fp = model_fp(2'b11, 32'h12345678, 32'h9ABCDEF0);
        e.res = model_res(2'b11, e.fp);
        sb.push_back(e);
        issue(2'b11, 32'h12345678, 32'h9ABCDEF0);
        wait_done(3, "bp");
        for (int i = 0; i < 5; i++) begin
            md = 2'(i);
            o1 = $urandom;
            o2 = $urandom;
            sv = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_dv", 64'(dv_m), 64'd1);
            chk("bp_sr", 64'(sr_m), 64'd0);
            chk("bp_res", 64'(res_m), 64'(last_res));
            chk("bp_fp", fp_m, last_fp);
        end
        sv = 1'b0;
        dr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_sr", 64'(sr_m), 64'd1);
        chk("bp_release_dv", 64'(dv_m), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_not_accepted", 64'(sr_m), 64'd1);

        // Flush during the second CALC cycle
        issue(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
        @(posedge clk);
        #1 fl = 1'b1;
        @(posedge clk);
        #1 fl = 1'b0;
        @(negedge clk);
        chk("fl_sr", 64'(sr_m), 64'd1);
        chk("fl_dv", 64'(dv_m), 64'd0);
        chk("fl_res_hold", 64'(res_m), 64'(last_res));
        chk("fl_fp_hold", fp_m, last_fp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fl_no_dv", 64'(dv_m), 64'd0);
        end
        run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA, 32'hFFFFFFFF, 3, "post_fl");

        // Flush together with start_valid in IDLE must not accept
        @(negedge clk);
        md = 2'b11; o1 = 32'h5; o2 = 32'h7; sv = 1'b1; fl = 1'b1;
        @(posedge clk);
        #1;
        sv = 1'b0;
        fl = 1'b0;
        @(negedge clk);
        chk("fl_idle_sr", 64'(sr_m), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fl_idle_no_dv", 64'(dv_m), 64'd0);
        end

        // Asynchronous reset mid-CALC
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dv", 64'(bus_a.done_valid), 64'd0);
        chk("arst_res", 64'(bus_a.result), 64'd0);
        chk("arst_fp", bus_a.full_product, 64'd0);
        chk("arst_res_b", 64'(bus_b.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_sr", 64'(sr_m), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_dv", 64'(dv_m), 64'd0);
        end
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 32'hFFFFFFFF, 3, "post_rst");

        // Random sweep, CHUNK=16
        for (int i = 0; i < 12; i++) begin
            run_rand(2'(i), 3, $sformatf("rnd_a%0d", i));
        end

        // CHUNK=8 instance (N=4 -> 5 edges)
        sel = 1'b1;
        @(negedge clk);
        run_op(2'b11, 32'h00010000, 32'h00010000, 64'h0000000100000000, 32'h00000001, 5, "c8_vec");
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].fp, tbl[i].res, 5, $sformatf("c8_tbl%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            run_rand(2'(i), 5, $sformatf("rnd_b%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
